// File: rtl/dmem_pkg.sv
// Shared types and default constants for the data-memory responder.
package dmem_pkg;

  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  // Request fields held for the life of one transaction.
  typedef struct packed {
    logic        we;
    logic        err;
    logic [31:0] wdata;
  } dmem_req_t;

  function automatic logic addr_oor(input logic [31:0] addr, input int depth);
    return addr >= 32'(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous write port, one combinational read port, no reset.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the MEM stage: accept, wait, respond.
// Optional DMEM_OOR_EN adds rsp_err and suppresses out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
`ifdef DMEM_OOR_EN
  output logic        rsp_err,
`endif
  output logic        stall
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_e   state;
  logic [3:0]    cnt;
  logic [AW-1:0] idx_q;
  dmem_req_t     lat_q;

  logic          req_err;
  logic          cur_we, cur_err;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word, resp_data;
  logic          mem_we;

`ifdef DMEM_OOR_EN
  assign req_err = addr_oor(req_addr, DEPTH);
`else
  logic unused_hi;
  assign req_err   = 1'b0;
  assign unused_hi = ^req_addr[31:AW];
`endif

  // With LATENCY=1 the response is formed on the accepting edge, so the read
  // port and the response fields come straight from the request in IDLE.
  assign rd_idx    = (state == IDLE) ? req_addr[AW-1:0] : idx_q;
  assign cur_we    = (state == IDLE) ? req_we  : lat_q.we;
  assign cur_err   = (state == IDLE) ? req_err : lat_q.err;
  assign resp_data = (cur_we || cur_err) ? 32'h0 : rd_word;

  assign mem_we    = (state == RESP) && lat_q.we && !lat_q.err;
  assign req_ready = (state == IDLE);
  assign stall     = (req_valid && state == IDLE) || (state == BUSY);

  dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (lat_q.wdata),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      idx_q     <= '0;
      lat_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
`ifdef DMEM_OOR_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
`ifdef DMEM_OOR_EN
      rsp_err   <= 1'b0;
`endif
      case (state)
        IDLE: if (req_valid) begin
          idx_q       <= req_addr[AW-1:0];
          lat_q.we    <= req_we;
          lat_q.err   <= req_err;
          lat_q.wdata <= req_wdata;
          cnt         <= CNT_INIT;
          if (LATENCY == 1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= resp_data;
`ifdef DMEM_OOR_EN
            rsp_err   <= cur_err;
`endif
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= resp_data;
`ifdef DMEM_OOR_EN
            rsp_err   <= cur_err;
`endif
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1 instances).
module tb_dmem_responder;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        v2, v1;
  logic        rdy2, rv2, st2, rdy1, rv1, st1;
  logic [31:0] rd2, rd1;
  logic        er2, er1;

  assign v2 = req_valid & ~sel;
  assign v1 = req_valid & sel;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(v2), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy2), .rsp_valid(rv2), .rsp_rdata(rd2),
`ifdef DMEM_OOR_EN
    .rsp_err(er2),
`endif
    .stall(st2));

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(rdy1), .rsp_valid(rv1), .rsp_rdata(rd1),
`ifdef DMEM_OOR_EN
    .rsp_err(er1),
`endif
    .stall(st1));

`ifndef DMEM_OOR_EN
  assign er2 = 1'b0;
  assign er1 = 1'b0;
`endif

  logic        o_ready, o_valid, o_stall, o_err;
  logic [31:0] o_rdata;
  assign o_ready = sel ? rdy1 : rdy2;
  assign o_valid = sel ? rv1  : rv2;
  assign o_stall = sel ? st1  : st2;
  assign o_err   = sel ? er1  : er2;
  assign o_rdata = sel ? rd1  : rd2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m2 [DEPTH];
  logic [31:0] m1 [DEPTH];

  function automatic logic is_oor(input logic [31:0] addr);
`ifdef DMEM_OOR_EN
    return addr >= 32'(DEPTH);
`else
    return 1'b0;
`endif
  endfunction

  // Reference memory: word index is the address modulo DEPTH.
  task automatic model_op(input logic s, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] exp_rd,
                          output logic exp_err);
    int i;
    i       = int'(addr % 32'(DEPTH));
    exp_err = is_oor(addr);
    exp_rd  = 32'h0;
    if (!we && !exp_err) exp_rd = s ? m1[i] : m2[i];
    if (we && !exp_err) begin
      if (s) m1[i] = wd; else m2[i] = wd;
    end
  endtask

  // Drives one isolated request and reports what came back.
  task automatic do_req(input logic s, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic err,
                        output int lat, output int st_cyc, output int viol);
    sel = s;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_valid = 1'b1;
    #1;
    viol   = 0;
    st_cyc = o_stall ? 1 : 0;
    if (!o_ready) viol++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    lat = -1; rd = 32'h0; err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      if (o_ready) viol++;
      if (o_valid) begin
        lat = k; rd = o_rdata; err = o_err;
        if (o_stall) viol++;
        break;
      end
      if (o_stall) st_cyc++; else viol++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({rdy2, rv2, rd2, st2} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h stall=%b, want 1 0 0 0",
               rdy2, rv2, rd2, st2);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({rdy1, rv1, rd1, st1, er2} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_after_release: got ready=%b valid=%b rdata=%h stall=%b err=%b",
               rdy1, rv1, rd1, st1, er2);
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd, wd;
    logic err, eerr;
    int lat, stc, viol, bad;
    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      wd = $urandom;
      model_op(1'b0, 1'b1, 32'(a), wd, erd, eerr);
      do_req(1'b0, 1'b1, 32'(a), wd, rd, err, lat, stc, viol);
      if (lat != 2 || rd !== 32'h0 || viol != 0 || stc != 2) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fill_stores: %0d bad store responses, want 0", bad);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat, stc, viol;
    model_op(1'b0, 1'b1, 32'd10, 32'h12345678, erd, eerr);
    do_req(1'b0, 1'b1, 32'd10, 32'h12345678, rd, err, lat, stc, viol);
    n_checks++;
    if (lat != 2 || rd !== 32'h0 || stc != 2 || viol != 0) begin
      n_fail++;
      $display("FAIL store10: lat=%0d rdata=%h stall_cycles=%0d viol=%0d, want 2 0 2 0",
               lat, rd, stc, viol);
    end
    model_op(1'b0, 1'b0, 32'd10, 32'h0, erd, eerr);
    do_req(1'b0, 1'b0, 32'd10, 32'h0, rd, err, lat, stc, viol);
    n_checks++;
    if (lat != 2 || rd !== 32'h12345678 || stc != 2 || viol != 0) begin
      n_fail++;
      $display("FAIL load10: lat=%0d rdata=%h stall_cycles=%0d viol=%0d, want 2 12345678 2 0",
               lat, rd, stc, viol);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd;
    logic err, eerr, we;
    int lat, stc, viol;
    for (int n = 0; n < 60; n++) begin
      we   = 1'($urandom);
      addr = 32'($urandom_range(0, 4 * DEPTH - 1));
      wd   = $urandom;
      model_op(1'b0, we, addr, wd, erd, eerr);
      do_req(1'b0, we, addr, wd, rd, err, lat, stc, viol);
      n_checks++;
      if (rd !== erd || err !== eerr || lat != 2 || viol != 0) begin
        n_fail++;
        $display("FAIL random_op%0d we=%b addr=%0d: rdata=%h err=%b lat=%0d viol=%0d, want %h %b 2 0",
                 n, we, addr, rd, err, lat, viol, erd, eerr);
      end
    end
  endtask

`ifdef DMEM_OOR_EN
  task automatic test_oor();
    logic [31:0] rd, erd, before;
    logic err, eerr;
    int lat, stc, viol;
    before = m2[44];
    do_req(1'b0, 1'b0, 32'd300, 32'h0, rd, err, lat, stc, viol);
    n_checks++;
    if (err !== 1'b1 || rd !== 32'h0 || lat != 2) begin
      n_fail++;
      $display("FAIL oor_load300: err=%b rdata=%h lat=%0d, want 1 0 2", err, rd, lat);
    end
    do_req(1'b0, 1'b1, 32'd300, 32'hBADBAD00, rd, err, lat, stc, viol);
    n_checks++;
    if (err !== 1'b1 || lat != 2) begin
      n_fail++;
      $display("FAIL oor_store300: err=%b lat=%0d, want 1 2", err, lat);
    end
    model_op(1'b0, 1'b0, 32'd44, 32'h0, erd, eerr);
    do_req(1'b0, 1'b0, 32'd44, 32'h0, rd, err, lat, stc, viol);
    n_checks++;
    if (rd !== before || err !== 1'b0) begin
      n_fail++;
      $display("FAIL oor_word44: rdata=%h err=%b, want %h 0", rd, err, before);
    end
  endtask
`else
  task automatic test_wrap();
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat, stc, viol;
    model_op(1'b0, 1'b1, 32'd260, 32'h77, erd, eerr);
    do_req(1'b0, 1'b1, 32'd260, 32'h77, rd, err, lat, stc, viol);
    do_req(1'b0, 1'b0, 32'd4, 32'h0, rd, err, lat, stc, viol);
    n_checks++;
    if (rd !== 32'h77 || lat != 2) begin
      n_fail++;
      $display("FAIL wrap_load4: rdata=%h lat=%0d, want 00000077 2", rd, lat);
    end
  endtask
`endif

  task automatic test_reset_mid_busy();
    logic [31:0] rd, erd, v;
    logic err, eerr;
    int lat, stc, viol, saw;
    v = $urandom;
    model_op(1'b0, 1'b1, 32'd5, v, erd, eerr);
    do_req(1'b0, 1'b1, 32'd5, v, rd, err, lat, stc, viol);
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'd5; req_wdata = 32'hDEAD; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({rdy2, rv2, st2} !== 3'b100) begin
      n_fail++;
      $display("FAIL rst_busy_state: ready=%b valid=%b stall=%b, want 1 0 0", rdy2, rv2, st2);
    end
    saw = 0;
    repeat (2) begin
      @(negedge clk);
      if (rv2) saw++;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      if (rv2) saw++;
    end
    n_checks++;
    if (saw != 0) begin
      n_fail++;
      $display("FAIL rst_busy_no_rsp: saw %0d rsp_valid pulses, want 0", saw);
    end
    model_op(1'b0, 1'b0, 32'd5, 32'h0, erd, eerr);
    do_req(1'b0, 1'b0, 32'd5, 32'h0, rd, err, lat, stc, viol);
    n_checks++;
    if (rd !== v) begin
      n_fail++;
      $display("FAIL rst_busy_word5: rdata=%h, want %h", rd, v);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] e [3];
    logic [31:0] got [3];
    int acc [3];
    int rsp [3];
    logic eerr;
    int na, nr, viol, extra;
    for (int i = 0; i < 3; i++) begin
      a[i] = 32'($urandom_range(0, DEPTH - 1));
      model_op(1'b0, 1'b0, a[i], 32'h0, e[i], eerr);
      acc[i] = -100; rsp[i] = -200; got[i] = 32'h0;
    end
    na = 0; nr = 0; viol = 0; extra = 0;
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_addr = a[0]; req_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nr < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (rv2) begin
        if (nr < 3) begin rsp[nr] = cyc; got[nr] = rd2; end
        nr++;
      end
      if (rv2 && rdy2) viol++;
      if (req_valid && rdy2) begin
        if (na < 3) acc[na] = cyc;
        na++;
        @(posedge clk);
        #1;
        if (na < 3) req_addr = a[na]; else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (rv2) extra++;
    end
    n_checks++;
    if (na != 3 || nr != 3 || extra != 0 || viol != 0) begin
      n_fail++;
      $display("FAIL b2b_counts: accepts=%0d rsps=%0d extra=%0d viol=%0d, want 3 3 0 0",
               na, nr, extra, viol);
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (got[i] !== e[i] || rsp[i] - acc[i] != 2 || (i > 0 && acc[i] - acc[i-1] != 3)) begin
        n_fail++;
        $display("FAIL b2b_load%0d: rdata=%h acc=%0d rsp=%0d, want %h rsp-acc=2 acc gap=3",
                 i, got[i], acc[i], rsp[i], e[i]);
      end
    end
  endtask

  task automatic test_latency1();
    logic [31:0] rd, erd;
    logic err, eerr;
    int lat, stc, viol;
    model_op(1'b1, 1'b1, 32'd3, 32'hA5A5A5A5, erd, eerr);
    do_req(1'b1, 1'b1, 32'd3, 32'hA5A5A5A5, rd, err, lat, stc, viol);
    n_checks++;
    if (lat != 1 || rd !== 32'h0 || stc != 1 || viol != 0) begin
      n_fail++;
      $display("FAIL lat1_store3: lat=%0d rdata=%h stall_cycles=%0d viol=%0d, want 1 0 1 0",
               lat, rd, stc, viol);
    end
    model_op(1'b1, 1'b0, 32'd3, 32'h0, erd, eerr);
    do_req(1'b1, 1'b0, 32'd3, 32'h0, rd, err, lat, stc, viol);
    n_checks++;
    if (lat != 1 || rd !== erd || stc != 1 || viol != 0) begin
      n_fail++;
      $display("FAIL lat1_load3: lat=%0d rdata=%h stall_cycles=%0d viol=%0d, want 1 %h 1 0",
               lat, rd, stc, viol, erd);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_store_load();
    test_random();
`ifdef DMEM_OOR_EN
    test_oor();
`else
    test_wrap();
`endif
    test_reset_mid_busy();
    test_back_to_back();
    test_latency1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in storage, power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request accept to rsp_valid, legal range 1..15.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  MEM-stage request present.
REQ-006 req_we  input  1  1 = store, 0 = load, sampled with req_valid.
REQ-007 req_addr  input  32  word address, same word addressing as the PC.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 rsp_valid  output  1  one-cycle pulse completing the accepted request.
REQ-011 rsp_rdata  output  32  load data, valid only with rsp_valid.
REQ-012 stall  output  1  pipeline freeze, high while a request is outstanding or being presented.

Function
REQ-013 FSM states: IDLE, BUSY, RESP; reset state IDLE.
REQ-014 A request is accepted on a rising edge where req_valid=1 and req_ready=1; req_ready=1 only in IDLE.
REQ-015 On accept, addr, we and wdata are latched and the latency counter loads LATENCY-1.
REQ-016 IDLE -> BUSY on accept when LATENCY>1; IDLE -> RESP on accept when LATENCY=1.
REQ-017 BUSY: decrement counter each cycle; BUSY -> RESP when counter reaches 1.
REQ-018 RESP: rsp_valid=1 for exactly one cycle, then RESP -> IDLE.
REQ-019 rsp_valid rises exactly LATENCY cycles after the accepting edge.
REQ-020 Store: the array word is written on the RESP->IDLE edge; rsp_rdata=0 during the store response.
REQ-021 Load: rsp_rdata is the array word at the latched address, including any store completed before the accept.
REQ-022 Without DMEM_OOR_EN, the index is req_addr mod DEPTH (low log2(DEPTH) bits).
REQ-023 stall = (req_valid & state==IDLE) | (state==BUSY); stall=0 in RESP so the pipeline advances on the response cycle.
REQ-024 Changes on req_* while in BUSY or RESP are ignored; only latched values are used.
REQ-025 A new request may be accepted on the first IDLE cycle after RESP; no back-to-back accept inside RESP.

Reset
REQ-026 Asserting rst at any time forces state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, req_ready=1 after deassertion, stall=0.
REQ-027 An outstanding store aborted by reset does not modify the array; array contents are not cleared by reset.

Configuration
REQ-028 Macro DMEM_OOR_EN: when defined, adds output rsp_err (1 bit, reset 0) that pulses with rsp_valid when req_addr >= DEPTH; an erroneous store leaves the array unchanged and an erroneous load returns 32'h0.
REQ-029 When DMEM_OOR_EN is undefined, rsp_err does not exist and addresses wrap per REQ-022.

Structure
REQ-030 Package dmem_pkg holds the FSM state typedef (IDLE/BUSY/RESP) and default constants DMEM_DEPTH=256 and DMEM_LATENCY=2.
REQ-031 The storage is a sub-module dmem_array (one synchronous write port, one combinational read port); dmem_responder holds the FSM, latches and counter.

Verification
REQ-032 Reset mid-BUSY: accept a store to 5 of 0xDEAD, assert rst one cycle later -> state IDLE, rsp_valid never pulses, a later load of 5 returns its pre-test value.
REQ-033 Store then load, LATENCY=2: store 0x12345678 to 10, then load 10 -> each rsp_valid is 2 cycles after its accept; the load returns 0x12345678.
REQ-034 LATENCY=1: load from address 3 (preloaded 0xA5A5A5A5) -> rsp_valid on the next edge, stall high for exactly 1 cycle.
REQ-035 Wrap, DEPTH=256, no macro: store 0x77 to 260, load 4 -> 0x77.
REQ-036 DMEM_OOR_EN: load 300 -> rsp_valid with rsp_err=1 and rsp_rdata=0; store to 300 then load 44 -> word 44 unchanged.
REQ-037 Back-to-back: req_valid held high with 3 loads -> accepts separated by LATENCY+1 cycles, req_ready low in BUSY/RESP, no lost or duplicated rsp_valid.
